// File: rtl/vsa16_mem_resp.sv
// Instruction/data memory responder: 16-word imem (registered fetch, program-load port)
// and 16-word dmem (combinational load). Optional range checking via VSA16_MEM_RANGE_CHECK_EN.
module vsa16_mem_resp (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] PC,
  output logic [15:0] instruction,
  input  logic [15:0] ALUOutput,
  input  logic [15:0] dataout,
  input  logic        wr,
  output logic [15:0] datain,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [7:0]  wr_count,
  output logic        proto_err,
  output logic        range_err
);

  logic [15:0] imem [16];
  logic [15:0] dmem [16];
  logic        prev_wr;
  logic [3:0]  fetch_idx;
  logic [3:0]  data_idx;
  logic        store_ok;

  assign fetch_idx = PC[4:1];
  assign data_idx  = ALUOutput[4:1];

`ifdef VSA16_MEM_RANGE_CHECK_EN
  logic data_bad;
  logic pc_bad;

  assign data_bad = ALUOutput[0] | (|ALUOutput[15:5]);
  assign pc_bad   = PC[0] | (|PC[11:5]);
  assign store_ok = wr & ~data_bad;

  always_ff @(posedge clock) begin
    if (reset) begin
      range_err <= 1'b0;
    end else if ((wr && data_bad) || pc_bad) begin
      range_err <= 1'b1;
    end
  end
`else
  assign store_ok  = wr;
  assign range_err = 1'b0;
`endif

  // Load data bypasses any register: a store becomes visible only after its edge.
  assign datain = dmem[data_idx];

  // NOTE: the memories are cleared on reset because the processor relies on
  // reading zeros right after reset; this forces flop-based storage, not RAM macros.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        imem[i] <= '0;
        dmem[i] <= '0;
      end
    end else begin
      if (prog_we) imem[prog_addr] <= prog_data;
      if (store_ok) dmem[data_idx] <= dataout;
    end
  end

  // NOTE: non-blocking assignment here is what makes a same-cycle program load
  // show the old word this cycle and the new word next cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction <= '0;
    end else begin
      instruction <= imem[fetch_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count  <= '0;
      prev_wr   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      prev_wr <= wr;
      if (wr && prev_wr) proto_err <= 1'b1;
      if (store_ok && (wr_count != 8'hFF)) wr_count <= wr_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_vsa16_mem_resp.sv
// Directed self-checking bench for vsa16_mem_resp; follows VSA16_MEM_RANGE_CHECK_EN if defined.
module tb_vsa16_mem_resp;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] PC;
  logic [15:0] instruction;
  logic [15:0] ALUOutput;
  logic [15:0] dataout;
  logic        wr;
  logic [15:0] datain;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [7:0]  wr_count;
  logic        proto_err;
  logic        range_err;

  int passed = 0;
  int total  = 0;

  vsa16_mem_resp dut (
    .clock      (clock),
    .reset      (reset),
    .PC         (PC),
    .instruction(instruction),
    .ALUOutput  (ALUOutput),
    .dataout    (dataout),
    .wr         (wr),
    .datain     (datain),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .wr_count   (wr_count),
    .proto_err  (proto_err),
    .range_err  (range_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = 1'b0; prog_we = 1'b0;
    PC = 12'h000; ALUOutput = 16'h0000; dataout = 16'h0000;
    prog_addr = 4'h0; prog_data = 16'h0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (instruction !== 16'h0000) $display("FAIL reset_instr: got %h expected 0000", instruction);
    else passed++;
    total++;
    if (wr_count !== 8'd0 || proto_err !== 1'b0 || range_err !== 1'b0)
      $display("FAIL reset_flags: got cnt=%0d pe=%b re=%b expected 0 0 0", wr_count, proto_err, range_err);
    else passed++;
    ALUOutput = 16'h001E; #1;
    total++;
    if (datain !== 16'h0000) $display("FAIL reset_datain: got %h expected 0000", datain);
    else passed++;
  endtask

  task automatic test_prog_load();
    do_reset();
    PC = 12'h006; prog_we = 1'b1; prog_addr = 4'd3; prog_data = 16'h1234;
    tick();
    prog_we = 1'b0;
    total++;
    if (instruction !== 16'h0000) $display("FAIL prog_old_word: got %h expected 0000", instruction);
    else passed++;
    tick();
    total++;
    if (instruction !== 16'h1234) $display("FAIL prog_new_word: got %h expected 1234", instruction);
    else passed++;
`ifndef VSA16_MEM_RANGE_CHECK_EN
    PC = 12'hFE7;
    tick();
    total++;
    if (instruction !== 16'h1234) $display("FAIL pc_wrap: got %h expected 1234", instruction);
    else passed++;
`endif
  endtask

  task automatic test_store();
    do_reset();
    ALUOutput = 16'h000A; dataout = 16'hBEEF; wr = 1'b1;
    #1;
    total++;
    if (datain !== 16'h0000) $display("FAIL store_old: got %h expected 0000", datain);
    else passed++;
    tick();
    wr = 1'b0; #1;
    total++;
    if (datain !== 16'hBEEF) $display("FAIL store_new: got %h expected beef", datain);
    else passed++;
    total++;
    if (wr_count !== 8'd1) $display("FAIL store_count: got %0d expected 1", wr_count);
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      wr = 1'b1; ALUOutput = 16'h0008; dataout = 16'(i);
      tick();
      wr = 1'b0;
      tick();
      if (i == 253) begin
        total++;
        if (wr_count !== 8'd254) $display("FAIL sat_254: got %0d expected 254", wr_count);
        else passed++;
      end
    end
    total++;
    if (wr_count !== 8'd255) $display("FAIL sat_255: got %0d expected 255", wr_count);
    else passed++;
    total++;
    if (proto_err !== 1'b0) $display("FAIL sat_proto: got %b expected 0", proto_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr = 1'b1; ALUOutput = 16'h0002; dataout = 16'h1111;
    tick();
    total++;
    if (proto_err !== 1'b0) $display("FAIL b2b_first_edge: got %b expected 0", proto_err);
    else passed++;
    ALUOutput = 16'h0004; dataout = 16'h2222;
    tick();
    wr = 1'b0;
    total++;
    if (proto_err !== 1'b1) $display("FAIL b2b_set: got %b expected 1", proto_err);
    else passed++;
    tick();
    total++;
    if (proto_err !== 1'b1) $display("FAIL b2b_sticky: got %b expected 1", proto_err);
    else passed++;
    ALUOutput = 16'h0002; #1;
    total++;
    if (datain !== 16'h1111) $display("FAIL b2b_word0: got %h expected 1111", datain);
    else passed++;
    ALUOutput = 16'h0004; #1;
    total++;
    if (datain !== 16'h2222) $display("FAIL b2b_word1: got %h expected 2222", datain);
    else passed++;
    total++;
    if (wr_count !== 8'd2) $display("FAIL b2b_count: got %0d expected 2", wr_count);
    else passed++;
  endtask

  task automatic test_range();
    do_reset();
    wr = 1'b1; ALUOutput = 16'h0021; dataout = 16'hCAFE;
    tick();
    wr = 1'b0; ALUOutput = 16'h0000; #1;
`ifdef VSA16_MEM_RANGE_CHECK_EN
    total++;
    if (range_err !== 1'b1) $display("FAIL range_flag: got %b expected 1", range_err);
    else passed++;
    total++;
    if (datain !== 16'h0000) $display("FAIL range_dmem: got %h expected 0000", datain);
    else passed++;
    total++;
    if (wr_count !== 8'd0) $display("FAIL range_count: got %0d expected 0", wr_count);
    else passed++;
`else
    total++;
    if (range_err !== 1'b0) $display("FAIL range_flag: got %b expected 0", range_err);
    else passed++;
    total++;
    if (datain !== 16'hCAFE) $display("FAIL range_wrap_dmem: got %h expected cafe", datain);
    else passed++;
    total++;
    if (wr_count !== 8'd1) $display("FAIL range_count: got %0d expected 1", wr_count);
    else passed++;
`endif
  endtask

  task automatic test_simultaneous();
    do_reset();
    wr = 1'b1; ALUOutput = 16'h0006; dataout = 16'h5555;
    prog_we = 1'b1; prog_addr = 4'd5; prog_data = 16'hAAAA; PC = 12'h00A;
    tick();
    wr = 1'b0; prog_we = 1'b0;
    tick();
    total++;
    if (instruction !== 16'hAAAA) $display("FAIL simul_imem: got %h expected aaaa", instruction);
    else passed++;
    total++;
    if (datain !== 16'h5555) $display("FAIL simul_dmem: got %h expected 5555", datain);
    else passed++;
    total++;
    if (wr_count !== 8'd1) $display("FAIL simul_count: got %0d expected 1", wr_count);
    else passed++;
  endtask

  task automatic test_reset_priority();
    int bad;
    // Populate memories and set proto_err before the reset under test.
    do_reset();
    wr = 1'b1; ALUOutput = 16'h0002; dataout = 16'h7777;
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 16'h8888;
    tick();
    ALUOutput = 16'h0004;
    tick();
    reset = 1'b1; wr = 1'b1; prog_we = 1'b1; prog_addr = 4'd3; prog_data = 16'h9999;
    ALUOutput = 16'h0006; dataout = 16'h6666; PC = 12'h002;
    tick();
    reset = 1'b0; wr = 1'b0; prog_we = 1'b0;
    total++;
    if (wr_count !== 8'd0 || proto_err !== 1'b0 || range_err !== 1'b0 || instruction !== 16'h0000)
      $display("FAIL rstpri_regs: got cnt=%0d pe=%b re=%b ins=%h expected 0 0 0 0000",
               wr_count, proto_err, range_err, instruction);
    else passed++;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      ALUOutput = {11'd0, 4'(i), 1'b0};
      PC = {7'd0, 4'(i), 1'b0};
      #1;
      if (datain !== 16'h0000) bad++;
      tick();
      if (instruction !== 16'h0000) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL rstpri_mem: got %0d nonzero words expected 0", bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_prog_load();
    test_store();
    test_saturation();
    test_back_to_back();
    test_range();
    test_simultaneous();
    test_reset_priority();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
